abc_inverse_search: RTL and testbench
=====================================

ABC_INVERSE_SEARCH -- requirements
Module: abc_inverse_search

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 req_valid  input  1  requester presents a target (y,z) pair.
REQ-004 req_y  input  1  target y value.
REQ-005 req_z  input  1  target z value.
REQ-006 strict  input  1  1 = exclude don't-care rows from matching; 0 = include them.
REQ-007 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-008 out_valid  output  1  result (out_a/b/c, out_miss) is valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_a, out_b, out_c  output  1 each  recovered input vector {a,b,c}.
REQ-011 out_miss  output  1  no candidate matched the target.

Function
REQ-012 Forward map (fixed): abc=111 -> (y,z)=(0,1); 110 -> (1,1); 100 -> (0,0); all other abc -> y=0, z don't-care ("DC rows": 000,001,010,011,101).
REQ-013 Match rule: non-DC row matches when both y and z equal target; DC row matches when strict=0 and target y=0 (z ignored); DC row never matches when strict=1.
REQ-014 States: IDLE, SEARCH, RESP; 2-bit encoding.
REQ-015 IDLE: req_ready=1, out_valid=0; on req_valid=1, latch req_y, req_z, strict, set cand=000, go SEARCH.
REQ-016 SEARCH: one candidate evaluated per cycle, ascending order 000 to 111; req_ready=0.
REQ-017 SEARCH, cand matches: register out_{a,b,c}=cand, out_miss=0, go RESP.
REQ-018 SEARCH, no match and cand=111: register out_{a,b,c}=000, out_miss=1, go RESP; cand never wraps.
REQ-019 SEARCH, no match and cand<111: cand increments by 1, remain SEARCH.
REQ-020 Latency: match at candidate index k asserts out_valid on the (k+1)th rising edge after the accepting edge; miss asserts on the 8th.
REQ-021 RESP: out_valid=1, result held stable until out_valid&out_ready; then go IDLE, out_valid=0 on that edge.
REQ-022 Back-to-back: req_valid during RESP or SEARCH is ignored (not latched); accepted only in IDLE, earliest one cycle after handshake completes.
REQ-023 Input pins req_y/req_z/strict changing after acceptance have no effect on the current search.
REQ-024 All outputs registered; no combinational path from req_* or out_ready to outputs except req_ready decoded from state.

Reset
REQ-025 rst=1 forces state IDLE, cand=000, out_valid=0, out_a=out_b=out_c=0, out_miss=0, latched target and strict cleared, on the same edge.
REQ-026 rst asserted during SEARCH or RESP aborts the operation; no result is delivered; req_ready=1 the cycle after rst deasserts.
REQ-027 rst has priority over every handshake in the same cycle.

Structure
REQ-028 Shared header abc_defs.vh holds state encodings (IDLE=00, SEARCH=01, RESP=10), CAND_W=3, CAND_LAST=3'b111.
REQ-029 One combinational sub-module abc_fwd_map: inputs abc[2:0], outputs y, z, dc (1 for DC rows); abc_inverse_search instantiates it on cand and applies REQ-013.
REQ-030 Unreachable state 11 shall return to IDLE on next edge.

Verification
REQ-031 strict=1, target (1,1) -> out_valid on 7th edge, abc=110, miss=0.
REQ-032 strict=1, target (0,0) -> abc=100 on 5th edge; strict=0, target (0,0) -> abc=000 on 1st edge.
REQ-033 strict=1 and strict=0, target (1,0) -> out_miss=1, abc=000, on 8th edge.
REQ-034 strict=1, target (0,1) -> abc=111 on 8th edge; hold out_ready=0 for 5 cycles -> outputs stable, req_ready=0, extra req_valid ignored.
REQ-035 rst pulsed at 3rd SEARCH cycle -> all outputs 0, state IDLE; new request (1,1) strict=1 completes normally.
REQ-036 Two requests back-to-back with out_ready tied 1 -> second accepted one cycle after first handshake; both results correct.

Source files
------------

// File: rtl/abc_inverse_search_pkg.sv
// Shared definitions for the ABC inverse search block: state encodings,
// candidate width and the match rule applied to each forward-mapped row.
package abc_inverse_search_pkg;

  localparam int unsigned CAND_W = 3;
  localparam logic [CAND_W-1:0] CAND_LAST = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_RESP   = 2'b10,
    ST_UNUSED = 2'b11
  } state_e;

  // A don't-care row only matches a y=0 target, and only in relaxed mode.
  function automatic logic cand_matches(input logic fwd_y, input logic fwd_z,
                                        input logic fwd_dc, input logic tgt_y,
                                        input logic tgt_z, input logic strict_mode);
    if (fwd_dc) begin
      return !strict_mode && !tgt_y;
    end
    return (fwd_y == tgt_y) && (fwd_z == tgt_z);
  endfunction

endpackage

// File: rtl/abc_inverse_search_fwd_map.sv
// Fixed forward map abc -> (y,z); rows outside the three defined ones
// produce y=0 and flag their z as don't-care.
module abc_fwd_map
  import abc_inverse_search_pkg::*;
(
  input  logic [CAND_W-1:0] abc,
  output logic              y,
  output logic              z,
  output logic              dc
);

  always_comb begin
    y  = 1'b0;
    z  = 1'b0;
    dc = 1'b0;
    case (abc)
      3'b111:  begin y = 1'b0; z = 1'b1; end
      3'b110:  begin y = 1'b1; z = 1'b1; end
      3'b100:  begin y = 1'b0; z = 1'b0; end
      default: dc = 1'b1;
    endcase
  end

endmodule

// File: rtl/abc_inverse_search.sv
// Sequential inverse search: walks candidates 000..111 one per cycle and
// returns the first abc whose forward image matches the latched target.
module abc_inverse_search
  import abc_inverse_search_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_y,
  input  logic req_z,
  input  logic strict,
  output logic req_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic out_a,
  output logic out_b,
  output logic out_c,
  output logic out_miss
);

  state_e            state_q, state_d;
  logic [CAND_W-1:0] cand_q, cand_d;
  logic              tgt_y_q, tgt_y_d;
  logic              tgt_z_q, tgt_z_d;
  logic              strict_q, strict_d;
  logic              out_valid_q, out_valid_d;
  logic [CAND_W-1:0] res_q, res_d;
  logic              miss_q, miss_d;

  logic fwd_y, fwd_z, fwd_dc, hit;

  abc_fwd_map u_fwd_map (
    .abc (cand_q),
    .y   (fwd_y),
    .z   (fwd_z),
    .dc  (fwd_dc)
  );

  assign hit = cand_matches(fwd_y, fwd_z, fwd_dc, tgt_y_q, tgt_z_q, strict_q);

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    tgt_y_d     = tgt_y_q;
    tgt_z_d     = tgt_z_q;
    strict_d    = strict_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    miss_d      = miss_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          tgt_y_d  = req_y;
          tgt_z_d  = req_z;
          strict_d = strict;
          cand_d   = '0;
          state_d  = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (hit) begin
          res_d       = cand_q;
          miss_d      = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cand_q == CAND_LAST) begin
          res_d       = '0;
          miss_d      = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cand_d = cand_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      tgt_y_q     <= 1'b0;
      tgt_z_q     <= 1'b0;
      strict_q    <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      tgt_y_q     <= tgt_y_d;
      tgt_z_q     <= tgt_z_d;
      strict_q    <= strict_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      miss_q      <= miss_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_a     = res_q[2];
  assign out_b     = res_q[1];
  assign out_c     = res_q[0];
  assign out_miss  = miss_q;

endmodule

// File: tb/tb_abc_inverse_search.sv
// Scoreboard bench for abc_inverse_search: expectations come from an
// independent model of the forward table and are popped when results appear.
module tb_abc_inverse_search;

  typedef struct packed {
    logic [2:0] abc;
    logic       miss;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst, req_valid, req_y, req_z, strict, out_ready;
  logic req_ready, out_valid, out_a, out_b, out_c, out_miss;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  abc_inverse_search dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_y     (req_y),
    .req_z     (req_z),
    .strict    (strict),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_miss  (out_miss)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic y, input logic z, input logic s);
    exp_t e;
    logic fy, fz, dc, hit;
    for (int k = 0; k < 8; k++) begin
      fy = 1'b0; fz = 1'b0; dc = 1'b0;
      if (k == 7)      fz = 1'b1;
      else if (k == 6) begin fy = 1'b1; fz = 1'b1; end
      else if (k != 4) dc = 1'b1;
      hit = dc ? (!s && !y) : (fy == y && fz == z);
      if (hit) begin
        e.abc = 3'(k); e.miss = 1'b0; e.lat = k + 1;
        return e;
      end
    end
    e.abc = 3'b000; e.miss = 1'b1; e.lat = 8;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request in IDLE, then scrambles the pins to show they are not re-sampled.
  task automatic issue(input logic y, input logic z, input logic s);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_timeout: req_ready=%b expected 1", req_ready);
    end
    req_valid = 1'b1; req_y = y; req_z = z; strict = s;
    sb.push_back(model(y, z, s));
    step();
    req_valid = 1'b0; req_y = ~y; req_z = ~z; strict = ~s;
  endtask

  task automatic wait_result(output int edges);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 20) begin step(); edges++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if ({req_ready, out_valid, out_a, out_b, out_c, out_miss} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b expected 100000",
               {req_ready, out_valid, out_a, out_b, out_c, out_miss});
    end
  endtask

  task automatic test_match();
    logic [2:0] pats [5] = '{3'b111, 3'b001, 3'b000, 3'b010, 3'b110};
    exp_t e;
    int   edges;
    for (int i = 0; i < 5; i++) begin
      issue(pats[i][2], pats[i][1], pats[i][0]);
      wait_result(edges);
      e = sb.pop_front();
      checks++;
      if ({out_a, out_b, out_c, out_miss} !== {e.abc, e.miss}) begin
        errors++;
        $display("[TB] FAIL match_result[%0d]: got %b expected %b", i,
                 {out_a, out_b, out_c, out_miss}, {e.abc, e.miss});
      end
      checks++;
      if (edges !== e.lat) begin
        errors++;
        $display("[TB] FAIL match_latency[%0d]: got %0d expected %0d", i, edges, e.lat);
      end
      handshake();
    end
  endtask

  task automatic test_miss();
    logic s;
    exp_t e;
    int   edges;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0);
      issue(1'b1, 1'b0, s);
      wait_result(edges);
      e = sb.pop_front();
      checks++;
      if ({out_a, out_b, out_c, out_miss} !== {e.abc, e.miss} || edges !== e.lat) begin
        errors++;
        $display("[TB] FAIL miss[%0d]: got %b after %0d edges expected %b after %0d", i,
                 {out_a, out_b, out_c, out_miss}, edges, {e.abc, e.miss}, e.lat);
      end
      handshake();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL miss_release[%0d]: out_valid=%b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int   edges;
    issue(1'b0, 1'b1, 1'b1);
    wait_result(edges);
    e = sb.pop_front();
    checks++;
    if ({out_a, out_b, out_c, out_miss} !== {e.abc, e.miss} || edges !== e.lat) begin
      errors++;
      $display("[TB] FAIL hold_result: got %b after %0d edges expected %b after %0d",
               {out_a, out_b, out_c, out_miss}, edges, {e.abc, e.miss}, e.lat);
    end
    req_valid = 1'b1; req_y = 1'b1; req_z = 1'b1; strict = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({req_ready, out_valid, out_a, out_b, out_c, out_miss} !== {2'b01, e.abc, e.miss}) begin
        errors++;
        $display("[TB] FAIL hold_stable[%0d]: got %b expected %b", i,
                 {req_ready, out_valid, out_a, out_b, out_c, out_miss}, {2'b01, e.abc, e.miss});
      end
    end
    req_valid = 1'b0;
    handshake();
    step(); step();
    checks++;
    if ({req_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL hold_ignored_req: ready/valid=%b expected 10", {req_ready, out_valid});
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   edges;
    int   seen = 0;
    req_valid = 1'b1; req_y = 1'b1; req_z = 1'b0; strict = 1'b1;
    step();
    req_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({req_ready, out_valid, out_a, out_b, out_c, out_miss} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL abort_state: got %b expected 100000",
               {req_ready, out_valid, out_a, out_b, out_c, out_miss});
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_result: out_valid cycles=%0d expected 0", seen);
    end
    issue(1'b1, 1'b1, 1'b1);
    wait_result(edges);
    e = sb.pop_front();
    checks++;
    if ({out_a, out_b, out_c, out_miss} !== {e.abc, e.miss} || edges !== e.lat) begin
      errors++;
      $display("[TB] FAIL abort_recover: got %b after %0d edges expected %b after %0d",
               {out_a, out_b, out_c, out_miss}, edges, {e.abc, e.miss}, e.lat);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   edges;
    out_ready = 1'b1;
    req_valid = 1'b1; req_y = 1'b1; req_z = 1'b1; strict = 1'b1;
    sb.push_back(model(1'b1, 1'b1, 1'b1));
    sb.push_back(model(1'b0, 1'b0, 1'b1));
    step();
    req_y = 1'b0; req_z = 1'b0;
    wait_result(edges);
    e = sb.pop_front();
    checks++;
    if ({out_a, out_b, out_c, out_miss} !== {e.abc, e.miss} || edges !== e.lat) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %b after %0d edges expected %b after %0d",
               {out_a, out_b, out_c, out_miss}, edges, {e.abc, e.miss}, e.lat);
    end
    step();
    checks++;
    if ({req_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL b2b_gap: ready/valid=%b expected 10", {req_ready, out_valid});
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_accept: req_ready=%b expected 0", req_ready);
    end
    wait_result(edges);
    e = sb.pop_front();
    checks++;
    if ({out_a, out_b, out_c, out_miss} !== {e.abc, e.miss} || edges !== e.lat) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %b after %0d edges expected %b after %0d",
               {out_a, out_b, out_c, out_miss}, edges, {e.abc, e.miss}, e.lat);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if ({req_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL b2b_done: ready/valid=%b expected 10", {req_ready, out_valid});
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_y = 1'b0; req_z = 1'b0;
    strict = 1'b0; out_ready = 1'b0;
    test_reset();
    test_match();
    test_miss();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
